// File: rtl/sysref_seq_pkg.sv
// Shared types and constants for the SYSREF sequencer and its period monitor.
package sysref_seq_pkg;

  typedef enum logic [2:0] {IDLE, ARM, RUN, DRAIN, DONE} seq_state_e;

  localparam int ARM_CYCLES           = 3;
  localparam int DRAIN_NOPULSE_CYCLES = 2;
  localparam int DRAIN_TIMEOUT_PAD    = 8;

  localparam logic MODE_CONT    = 1'b0;
  localparam logic MODE_COUNTED = 1'b1;

endpackage

// File: rtl/sysref_sequencer_period_monitor.sv
// SYSREF edge detect plus interval counter; flags any pulse interval in RUN that is not exactly P.
module sysref_period_monitor
  import sysref_seq_pkg::*;
#(
  parameter int P_W = 17
) (
  input  logic           coreclk,
  input  logic           reset_n,
  input  logic           sysref_in,
  input  logic           restart,
  input  logic           check_en,
  input  logic           clear,
  input  logic [P_W-1:0] period,
  output logic           rise,
  output logic           period_err
);

  localparam int C_W = P_W + 1;

  logic           sysref_d;
  logic [C_W-1:0] ival;

  assign rise = sysref_in & ~sysref_d;

  // ival holds the number of cycles since gen_reset fell or since the last pulse
  always_ff @(posedge coreclk) begin
    if (!reset_n) begin
      sysref_d   <= 1'b0;
      ival       <= '0;
      period_err <= 1'b0;
    end else begin
      sysref_d <= sysref_in;
      if (restart)
        ival <= '0;
      else if (rise)
        ival <= C_W'(1);
      else if (ival != '1)
        ival <= ival + 1'b1;

      if (clear)
        period_err <= 1'b0;
      else if (check_en && ((rise && ival != C_W'(period)) || (!rise && ival == '1)))
        period_err <= 1'b1;
    end
  end

endmodule

// File: rtl/sysref_sequencer.sv
// SYSREF generator sequencer: configure, arm, run, drain and report status.
// Optional SYSREF_SEQ_PERIOD_CHECK_EN builds the pulse-interval checker.
module sysref_sequencer
  import sysref_seq_pkg::*;
#(
  parameter int K_W   = 6,
  parameter int F_W   = 9,
  parameter int CNT_W = 16
) (
  input  logic             coreclk,
  input  logic             reset_n,
  input  logic [K_W-1:0]   cfg_k,
  input  logic [F_W-1:0]   cfg_f,
  input  logic             cfg_mode,
  input  logic [CNT_W-1:0] cfg_pulse_num,
  input  logic             cfg_single_pulse_on_stop,
  input  logic             start,
  input  logic             stop,
  input  logic             sysref_in,
  output logic             gen_reset,
  output logic [K_W-1:0]   gen_k_value,
  output logic [F_W-1:0]   gen_f_value,
  output logic             gen_stop_generating,
  output logic             gen_no_single_pulse_after_stop,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic [CNT_W-1:0] pulse_count,
  output logic             timeout_err,
  output logic             period_err
);

  localparam int P_W  = K_W + F_W + 2;
  localparam int PH_W = K_W + F_W + 3;

  seq_state_e       state, state_nxt;
  logic [P_W-1:0]   p_q, p_calc;
  logic [PH_W-1:0]  phase_cnt, timeout_lim;
  logic [CNT_W-1:0] pulse_num_q, cnt_inc;
  logic             mode_q, single_q, trail_q;
  logic             rise, cfg_ok;
  logic             accept, reject, stop_trail, count_pulse, timeout_hit;

  assign cfg_ok      = (cfg_k != '0) && (cfg_f != '0) &&
                       (cfg_mode == MODE_CONT || cfg_pulse_num != '0);
  assign p_calc      = (P_W'(cfg_k) * P_W'(cfg_f)) << 2;
  assign timeout_lim = PH_W'(p_q) + PH_W'(DRAIN_TIMEOUT_PAD - 1);
  assign cnt_inc     = (&pulse_count) ? pulse_count : pulse_count + 1'b1;

`ifdef SYSREF_SEQ_PERIOD_CHECK_EN
  logic restart, check_en;
  assign restart  = (state == ARM) && (state_nxt == RUN);
  assign check_en = (state == RUN);

  sysref_period_monitor #(.P_W(P_W)) u_period_monitor (
    .coreclk    (coreclk),
    .reset_n    (reset_n),
    .sysref_in  (sysref_in),
    .restart    (restart),
    .check_en   (check_en),
    .clear      (accept),
    .period     (p_q),
    .rise       (rise),
    .period_err (period_err)
  );
`else
  logic sysref_d;
  always_ff @(posedge coreclk) begin
    if (!reset_n) sysref_d <= 1'b0;
    else          sysref_d <= sysref_in;
  end
  assign rise       = sysref_in & ~sysref_d;
  assign period_err = 1'b0;
`endif

  always_ff @(posedge coreclk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    reject      = 1'b0;
    stop_trail  = 1'b0;
    count_pulse = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            accept    = 1'b1;
            state_nxt = ARM;
          end else begin
            reject = 1'b1;
          end
        end
      end
      ARM: begin
        if (stop)
          state_nxt = DRAIN;
        else if (phase_cnt == PH_W'(ARM_CYCLES - 1))
          state_nxt = RUN;
      end
      RUN: begin
        count_pulse = rise;
        // The Nth pulse wins over a coincident stop: counted completion never expects a trailer
        if (rise && mode_q == MODE_COUNTED && cnt_inc == pulse_num_q) begin
          state_nxt = DRAIN;
        end else if (stop) begin
          state_nxt  = DRAIN;
          stop_trail = single_q;
        end
      end
      DRAIN: begin
        if (trail_q) begin
          if (rise) begin
            count_pulse = 1'b1;
            state_nxt   = DONE;
          end else if (phase_cnt == timeout_lim) begin
            timeout_hit = 1'b1;
            state_nxt   = DONE;
          end
        end else if (phase_cnt == PH_W'(DRAIN_NOPULSE_CYCLES - 1)) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge coreclk) begin
    if (!reset_n) begin
      gen_reset                      <= 1'b1;
      gen_stop_generating            <= 1'b1;
      gen_no_single_pulse_after_stop <= 1'b1;
      gen_k_value                    <= '0;
      gen_f_value                    <= '0;
      pulse_count                    <= '0;
      busy                           <= 1'b0;
      done                           <= 1'b0;
      cfg_err                        <= 1'b0;
      timeout_err                    <= 1'b0;
      p_q                            <= '0;
      phase_cnt                      <= '0;
      pulse_num_q                    <= '0;
      mode_q                         <= MODE_CONT;
      single_q                       <= 1'b0;
      trail_q                        <= 1'b0;
    end else begin
      busy                <= (state_nxt != IDLE);
      done                <= (state == DONE);
      cfg_err             <= reject;
      gen_stop_generating <= (state_nxt inside {IDLE, DRAIN, DONE});
      phase_cnt           <= (state_nxt != state) ? '0 : phase_cnt + 1'b1;

      // gen_reset stays high through a DRAIN entered from ARM
      if (state_nxt inside {IDLE, ARM, DONE})
        gen_reset <= 1'b1;
      else if (state_nxt == RUN)
        gen_reset <= 1'b0;

      if (accept) begin
        gen_k_value                    <= cfg_k;
        gen_f_value                    <= cfg_f;
        gen_no_single_pulse_after_stop <= ~cfg_single_pulse_on_stop;
        p_q                            <= p_calc;
        pulse_num_q                    <= cfg_pulse_num;
        mode_q                         <= cfg_mode;
        single_q                       <= cfg_single_pulse_on_stop;
        pulse_count                    <= '0;
        timeout_err                    <= 1'b0;
      end else if (count_pulse) begin
        pulse_count <= cnt_inc;
      end

      if (timeout_hit)
        timeout_err <= 1'b1;

      // Suppress the generator's trailer whenever the drain will not wait for it
      if (state_nxt == DRAIN && state != DRAIN) begin
        trail_q <= stop_trail;
        if (!stop_trail)
          gen_no_single_pulse_after_stop <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sysref_sequencer.sv
// Directed self-checking bench for sysref_sequencer; honours SYSREF_SEQ_PERIOD_CHECK_EN.
module tb_sysref_sequencer;

  localparam int K_W   = 6;
  localparam int F_W   = 9;
  localparam int CNT_W = 16;
`ifdef SYSREF_SEQ_PERIOD_CHECK_EN
  localparam logic PCHK = 1'b1;
`else
  localparam logic PCHK = 1'b0;
`endif

  logic             coreclk = 1'b0;
  logic             reset_n = 1'b0;
  logic [K_W-1:0]   cfg_k = '0;
  logic [F_W-1:0]   cfg_f = '0;
  logic             cfg_mode = 1'b0;
  logic [CNT_W-1:0] cfg_pulse_num = '0;
  logic             cfg_single_pulse_on_stop = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             sysref_in = 1'b0;
  logic             gen_reset, gen_stop_generating, gen_no_single_pulse_after_stop;
  logic [K_W-1:0]   gen_k_value;
  logic [F_W-1:0]   gen_f_value;
  logic             busy, done, cfg_err, timeout_err, period_err;
  logic [CNT_W-1:0] pulse_count;

  int checks = 0;
  int errors = 0;

  always #5 coreclk = ~coreclk;

  sysref_sequencer #(.K_W(K_W), .F_W(F_W), .CNT_W(CNT_W)) dut (
    .coreclk                        (coreclk),
    .reset_n                        (reset_n),
    .cfg_k                          (cfg_k),
    .cfg_f                          (cfg_f),
    .cfg_mode                       (cfg_mode),
    .cfg_pulse_num                  (cfg_pulse_num),
    .cfg_single_pulse_on_stop       (cfg_single_pulse_on_stop),
    .start                          (start),
    .stop                           (stop),
    .sysref_in                      (sysref_in),
    .gen_reset                      (gen_reset),
    .gen_k_value                    (gen_k_value),
    .gen_f_value                    (gen_f_value),
    .gen_stop_generating            (gen_stop_generating),
    .gen_no_single_pulse_after_stop (gen_no_single_pulse_after_stop),
    .busy                           (busy),
    .done                           (done),
    .cfg_err                        (cfg_err),
    .pulse_count                    (pulse_count),
    .timeout_err                    (timeout_err),
    .period_err                     (period_err)
  );

  typedef struct {
    logic [K_W-1:0]   k;
    logic [F_W-1:0]   f;
    logic             mode;
    logic [CNT_W-1:0] num;
    logic             single;
    logic             stp;
    logic             exp_busy;
    logic             exp_err;
    logic             exp_stop;
    logic             exp_nosingle;
    logic [K_W-1:0]   exp_k;
    logic [F_W-1:0]   exp_f;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge coreclk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic doReset();
    reset_n   = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    sysref_in = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic applyStimulus(input logic [K_W-1:0] k, input logic [F_W-1:0] f, input logic mode,
                               input logic [CNT_W-1:0] num, input logic single, input logic stp);
    cfg_k                    = k;
    cfg_f                    = f;
    cfg_mode                 = mode;
    cfg_pulse_num            = num;
    cfg_single_pulse_on_stop = single;
    start                    = 1'b1;
    stop                     = stp;
    tick();
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic pulse();
    sysref_in = 1'b1;
    tick();
    sysref_in = 1'b0;
  endtask

  task automatic armToRun();
    tick();
    tick();
    checkOutput("gen_reset_in_arm", gen_reset, 1);
    tick();
    checkOutput("gen_reset_fall", gen_reset, 0);
  endtask

  task automatic stopPulse();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  initial begin
    vecs[0] = '{6'd2,  9'd3,   1'b1, 16'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 6'd2,  9'd3};
    vecs[1] = '{6'd0,  9'd3,   1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'd0,  9'd0};
    vecs[2] = '{6'd2,  9'd0,   1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'd0,  9'd0};
    vecs[3] = '{6'd1,  9'd1,   1'b1, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'd0,  9'd0};
    vecs[4] = '{6'd1,  9'd1,   1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd1,  9'd1};
    vecs[5] = '{6'd63, 9'd511, 1'b1, 16'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd63, 9'd511};
    vecs[6] = '{6'd1,  9'd0,   1'b1, 16'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 6'd0,  9'd0};

    tick();
    doReset();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_gen_reset", gen_reset, 1);
    checkOutput("rst_gen_stop", gen_stop_generating, 1);
    checkOutput("rst_no_single", gen_no_single_pulse_after_stop, 1);
    checkOutput("rst_gen_k", gen_k_value, 0);
    checkOutput("rst_gen_f", gen_f_value, 0);
    checkOutput("rst_pulse_count", pulse_count, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_cfg_err", cfg_err, 0);
    checkOutput("rst_timeout_err", timeout_err, 0);
    checkOutput("rst_period_err", period_err, 0);

    // start accept/reject table, each vector from a fresh reset
    for (int i = 0; i < 7; i++) begin
      doReset();
      applyStimulus(vecs[i].k, vecs[i].f, vecs[i].mode, vecs[i].num, vecs[i].single, vecs[i].stp);
      checkOutput($sformatf("v%0d_busy", i), busy, vecs[i].exp_busy);
      checkOutput($sformatf("v%0d_cfg_err", i), cfg_err, vecs[i].exp_err);
      checkOutput($sformatf("v%0d_gen_stop", i), gen_stop_generating, vecs[i].exp_stop);
      checkOutput($sformatf("v%0d_no_single", i), gen_no_single_pulse_after_stop, vecs[i].exp_nosingle);
      checkOutput($sformatf("v%0d_gen_k", i), gen_k_value, vecs[i].exp_k);
      checkOutput($sformatf("v%0d_gen_f", i), gen_f_value, vecs[i].exp_f);
      checkOutput($sformatf("v%0d_gen_reset", i), gen_reset, 1);
      tick();
      checkOutput($sformatf("v%0d_cfg_err_clr", i), cfg_err, 0);
      checkOutput($sformatf("v%0d_gen_stop_2", i), gen_stop_generating, vecs[i].exp_stop);
    end

    // counted mode K=2 F=3 N=4, P=24
    doReset();
    applyStimulus(6'd2, 9'd3, 1'b1, 16'd4, 1'b0, 1'b0);
    armToRun();
    cfg_k = 6'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("c_start_ignored_k", gen_k_value, 2);
    checkOutput("c_start_ignored_err", cfg_err, 0);
    repeat (23) tick();
    pulse();
    checkOutput("c_count_1", pulse_count, 1);
    for (int i = 2; i <= 4; i++) begin
      repeat (23) tick();
      pulse();
      checkOutput($sformatf("c_count_%0d", i), pulse_count, i);
    end
    checkOutput("c_drain_stop", gen_stop_generating, 1);
    checkOutput("c_drain_busy", busy, 1);
    tick();
    tick();
    checkOutput("c_done_state_reset", gen_reset, 1);
    checkOutput("c_done_not_yet", done, 0);
    tick();
    checkOutput("c_done", done, 1);
    checkOutput("c_idle_busy", busy, 0);
    checkOutput("c_final_count", pulse_count, 4);
    checkOutput("c_timeout_err", timeout_err, 0);
    checkOutput("c_period_err", period_err, 0);
    tick();
    checkOutput("c_done_one_cycle", done, 0);

    // rejected start keeps previous generator config
    applyStimulus(6'd2, 9'd3, 1'b1, 16'd0, 1'b0, 1'b0);
    checkOutput("r_cfg_err", cfg_err, 1);
    checkOutput("r_busy", busy, 0);
    checkOutput("r_gen_k_kept", gen_k_value, 2);
    checkOutput("r_gen_f_kept", gen_f_value, 3);
    tick();
    checkOutput("r_cfg_err_clr", cfg_err, 0);

    // continuous K=1 F=1 (P=4), stop after 3 pulses, trailing pulse allowed
    doReset();
    applyStimulus(6'd1, 9'd1, 1'b0, 16'd0, 1'b1, 1'b0);
    checkOutput("t_no_single", gen_no_single_pulse_after_stop, 0);
    armToRun();
    repeat (4) tick();
    pulse();
    repeat (3) tick();
    pulse();
    repeat (3) tick();
    pulse();
    checkOutput("t_count_3", pulse_count, 3);
    stopPulse();
    checkOutput("t_drain_stop", gen_stop_generating, 1);
    checkOutput("t_drain_gen_reset", gen_reset, 0);
    repeat (3) tick();
    pulse();
    checkOutput("t_count_4", pulse_count, 4);
    checkOutput("t_done_gen_reset", gen_reset, 1);
    tick();
    checkOutput("t_done", done, 1);
    checkOutput("t_timeout_err", timeout_err, 0);
    checkOutput("t_period_err", period_err, 0);

    // trailing pulse never arrives: K=1 F=2 (P=8), timeout after 16 cycles
    doReset();
    applyStimulus(6'd1, 9'd2, 1'b0, 16'd0, 1'b1, 1'b0);
    armToRun();
    repeat (8) tick();
    pulse();
    checkOutput("to_count_1", pulse_count, 1);
    stopPulse();
    repeat (15) tick();
    checkOutput("to_not_yet", timeout_err, 0);
    checkOutput("to_still_busy", busy, 1);
    tick();
    checkOutput("to_timeout_set", timeout_err, 1);
    checkOutput("to_done_gen_reset", gen_reset, 1);
    tick();
    checkOutput("to_done", done, 1);
    tick();
    checkOutput("to_sticky", timeout_err, 1);
    checkOutput("to_done_clr", done, 0);

    // reset while running
    doReset();
    applyStimulus(6'd1, 9'd1, 1'b0, 16'd0, 1'b0, 1'b0);
    armToRun();
    repeat (4) tick();
    pulse();
    repeat (3) tick();
    pulse();
    checkOutput("mr_count_2", pulse_count, 2);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checkOutput("mr_busy", busy, 0);
    checkOutput("mr_gen_reset", gen_reset, 1);
    checkOutput("mr_gen_stop", gen_stop_generating, 1);
    checkOutput("mr_count", pulse_count, 0);
    checkOutput("mr_gen_k", gen_k_value, 0);
    checkOutput("mr_done", done, 0);
    tick();
    checkOutput("mr_no_done", done, 0);

    // early pulse at P/2 with K=2 F=2 (P=16)
    doReset();
    applyStimulus(6'd2, 9'd2, 1'b0, 16'd0, 1'b0, 1'b0);
    armToRun();
    repeat (8) tick();
    pulse();
    checkOutput("pe_count_1", pulse_count, 1);
    checkOutput("pe_period_err", period_err, PCHK);
    repeat (15) tick();
    pulse();
    checkOutput("pe_sticky_run", period_err, PCHK);
    stopPulse();
    repeat (3) tick();
    checkOutput("pe_done", done, 1);
    checkOutput("pe_sticky_idle", period_err, PCHK);
    applyStimulus(6'd1, 9'd1, 1'b0, 16'd0, 1'b0, 1'b0);
    checkOutput("pe_cleared_on_start", period_err, 0);
    checkOutput("pe_count_cleared", pulse_count, 0);
    doReset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
